// File: rtl/pipelined_main_decoder_pkg.sv
// decoder_pkg: opcodes, control-field encodings and the bundled control word
package decoder_pkg;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_src_e;
   typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4} result_src_e;
   typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_PASSB} alu_op_e;
   typedef struct packed {
      logic        reg_write;
      imm_src_e    imm_src;
      logic        alu_src;
      logic        mem_write;
      result_src_e result_src;
      logic        branch;
      logic        jump;
      alu_op_e     alu_op;
      logic        illegal;
   } ctrl_t;
   function automatic ctrl_t mk_ctrl(logic rw, imm_src_e imm, logic as, logic mw, result_src_e rs,
                                     logic br, logic j, alu_op_e op);
      return '{reg_write: rw, imm_src: imm, alu_src: as, mem_write: mw, result_src: rs,
               branch: br, jump: j, alu_op: op, illegal: 1'b0};
   endfunction
endpackage

// File: rtl/pipelined_main_decoder_if.sv
// pipelined_main_decoder_if: fetch-side and execute-side handshake bundle
interface pipelined_main_decoder_if #(parameter int INSTR_W = 32, parameter int PC_W = 32);
   logic               flush;
   logic               in_valid, in_ready;
   logic [INSTR_W-1:0] in_instr;
   logic [PC_W-1:0]    in_pc;
   logic               out_valid, out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [PC_W-1:0]    out_pc;
   logic               RegWrite, ALUSrc, MemWrite, Branch, Jump, Illegal;
   logic [2:0]         ImmSrc;
   logic [1:0]         ResultSrc, ALUOp;
   modport master (output flush, in_valid, in_instr, in_pc, out_ready,
                   input in_ready, out_valid, out_instr, out_pc, RegWrite, ImmSrc, ALUSrc,
                   MemWrite, ResultSrc, Branch, Jump, ALUOp, Illegal);
   modport slave (input flush, in_valid, in_instr, in_pc, out_ready,
                  output in_ready, out_valid, out_instr, out_pc, RegWrite, ImmSrc, ALUSrc,
                  MemWrite, ResultSrc, Branch, Jump, ALUOp, Illegal);
endinterface

// File: rtl/pipelined_main_decoder_main_decode_comb.sv
// main_decode_comb: opcode to control word; anything outside the table is illegal
module main_decode_comb
   import decoder_pkg::*;
(
   input  logic [6:0] opcode_i,
   output ctrl_t      ctrl_o
);
   always_comb begin
      ctrl_o = '0;
      ctrl_o.illegal = 1'b1;
      case (opcode_i)
         OP_LOAD:   ctrl_o = mk_ctrl(1'b1, IMM_I, 1'b1, 1'b0, RES_MEM, 1'b0, 1'b0, ALU_ADD);
         OP_STORE:  ctrl_o = mk_ctrl(1'b0, IMM_S, 1'b1, 1'b1, RES_ALU, 1'b0, 1'b0, ALU_ADD);
         OP_RTYPE:  ctrl_o = mk_ctrl(1'b1, IMM_I, 1'b0, 1'b0, RES_ALU, 1'b0, 1'b0, ALU_FUNCT);
         OP_ITYPE:  ctrl_o = mk_ctrl(1'b1, IMM_I, 1'b1, 1'b0, RES_ALU, 1'b0, 1'b0, ALU_FUNCT);
         OP_BRANCH: ctrl_o = mk_ctrl(1'b0, IMM_B, 1'b0, 1'b0, RES_ALU, 1'b1, 1'b0, ALU_SUB);
         OP_JAL:    ctrl_o = mk_ctrl(1'b1, IMM_J, 1'b0, 1'b0, RES_PC4, 1'b0, 1'b1, ALU_ADD);
         OP_JALR:   ctrl_o = mk_ctrl(1'b1, IMM_I, 1'b1, 1'b0, RES_PC4, 1'b0, 1'b1, ALU_ADD);
         OP_LUI:    ctrl_o = mk_ctrl(1'b1, IMM_U, 1'b1, 1'b0, RES_ALU, 1'b0, 1'b0, ALU_PASSB);
         default: ;
      endcase
   end
endmodule

// File: rtl/pipelined_main_decoder.sv
// pipelined_main_decoder: registered main decoder with one-entry skid buffer.
// DECODER_PERF_EN adds saturating issued/illegal/stall counters.
module pipelined_main_decoder
   import decoder_pkg::*;
#(
   parameter int INSTR_W = 32,
   parameter int PC_W    = 32
`ifdef DECODER_PERF_EN
   , parameter int CNT_W = 16
`endif
) (
   input logic clk,
   input logic rst,
   pipelined_main_decoder_if.slave bus
`ifdef DECODER_PERF_EN
   , output logic [CNT_W-1:0] cnt_issued
   , output logic [CNT_W-1:0] cnt_illegal
   , output logic [CNT_W-1:0] cnt_stall
`endif
);
   logic               main_v_q, skid_v_q;
   logic [INSTR_W-1:0] main_instr_q, skid_instr_q, src_instr;
   logic [PC_W-1:0]    main_pc_q, skid_pc_q, src_pc;
   ctrl_t              main_ctrl_q, src_ctrl;
   logic               accept, adv, src_v;
   assign accept    = bus.in_valid & ~skid_v_q;
   assign adv       = ~main_v_q | bus.out_ready;
   assign src_v     = skid_v_q | accept;
   assign src_instr = skid_v_q ? skid_instr_q : bus.in_instr;
   assign src_pc    = skid_v_q ? skid_pc_q : bus.in_pc;
   main_decode_comb u_dec (.opcode_i(src_instr[6:0]), .ctrl_o(src_ctrl));
   // skid is older than any new input, so it always refills main first
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_v_q     <= 1'b0;
         skid_v_q     <= 1'b0;
         main_instr_q <= '0;
         main_pc_q    <= '0;
         main_ctrl_q  <= '0;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
      end else if (bus.flush) begin
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
      end else if (adv) begin
         main_v_q <= src_v;
         skid_v_q <= 1'b0;
         if (src_v) begin
            main_instr_q <= src_instr;
            main_pc_q    <= src_pc;
            main_ctrl_q  <= src_ctrl;
         end
      end else if (accept) begin
         skid_v_q     <= 1'b1;
         skid_instr_q <= bus.in_instr;
         skid_pc_q    <= bus.in_pc;
      end
   end
   assign bus.in_ready  = ~skid_v_q;
   assign bus.out_valid = main_v_q;
   assign bus.out_instr = main_instr_q;
   assign bus.out_pc    = main_pc_q;
   assign bus.RegWrite  = main_v_q & main_ctrl_q.reg_write;
   assign bus.ImmSrc    = main_ctrl_q.imm_src;
   assign bus.ALUSrc    = main_ctrl_q.alu_src;
   assign bus.MemWrite  = main_v_q & main_ctrl_q.mem_write;
   assign bus.ResultSrc = main_ctrl_q.result_src;
   assign bus.Branch    = main_v_q & main_ctrl_q.branch;
   assign bus.Jump      = main_v_q & main_ctrl_q.jump;
   assign bus.ALUOp     = main_ctrl_q.alu_op;
   assign bus.Illegal   = main_v_q & main_ctrl_q.illegal;
`ifdef DECODER_PERF_EN
   logic issue, stall;
   assign issue = main_v_q & bus.out_ready;
   assign stall = main_v_q & ~bus.out_ready;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_issued  <= '0;
         cnt_illegal <= '0;
         cnt_stall   <= '0;
      end else begin
         if (issue && !(&cnt_issued)) cnt_issued <= cnt_issued + CNT_W'(1);
         if (issue && main_ctrl_q.illegal && !(&cnt_illegal)) cnt_illegal <= cnt_illegal + CNT_W'(1);
         if (stall && !(&cnt_stall)) cnt_stall <= cnt_stall + CNT_W'(1);
      end
   end
`endif
endmodule

// File: tb/tb_pipelined_main_decoder.sv
// tb_pipelined_main_decoder: scoreboard bench with a table-lookup decode model
module tb_pipelined_main_decoder;
   localparam int IW = 32;
   localparam int PW = 32;
   localparam int CW = 4;
   typedef struct packed {
      logic [IW-1:0] instr;
      logic [PW-1:0] pc;
      logic [12:0]   ctrl;
   } exp_t;
   localparam logic [6:0] OPS [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
   // RegWrite,ImmSrc,ALUSrc,MemWrite,ResultSrc,Branch,Jump,ALUOp
   localparam logic [11:0] ROWS [8] = '{12'b1_000_1_0_01_0_0_00, 12'b0_001_1_1_00_0_0_00,
                                        12'b1_000_0_0_00_0_0_10, 12'b1_000_1_0_00_0_0_10,
                                        12'b0_010_0_0_00_1_0_01, 12'b1_011_0_0_10_0_1_00,
                                        12'b1_000_1_0_10_0_1_00, 12'b1_100_1_0_00_0_0_11};
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t sb[$];
   always #5 clk = ~clk;
   pipelined_main_decoder_if #(.INSTR_W(IW), .PC_W(PW)) dif ();
`ifdef DECODER_PERF_EN
   logic [CW-1:0] cnt_issued, cnt_illegal, cnt_stall;
`endif
   pipelined_main_decoder #(
      .INSTR_W(IW), .PC_W(PW)
`ifdef DECODER_PERF_EN
      , .CNT_W(CW)
`endif
   ) dut (
      .clk(clk), .rst(rst), .bus(dif)
`ifdef DECODER_PERF_EN
      , .cnt_issued(cnt_issued), .cnt_illegal(cnt_illegal), .cnt_stall(cnt_stall)
`endif
   );
   function automatic logic [12:0] ref_ctrl(logic [31:0] ins);
      if (ins[1:0] != 2'b11) return 13'b1;
      for (int i = 0; i < 8; i++) if (ins[6:0] == OPS[i]) return {ROWS[i], 1'b0};
      return 13'b1;
   endfunction
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (rst && dif.out_valid && dif.out_ready) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_issue: got instr %h expected nothing", dif.out_instr);
         end else begin
            e = sb.pop_front();
            chk("issue_instr", dif.out_instr, e.instr);
            chk("issue_pc", dif.out_pc, e.pc);
            chk("issue_ctrl", {dif.RegWrite, dif.ImmSrc, dif.ALUSrc, dif.MemWrite, dif.ResultSrc,
                               dif.Branch, dif.Jump, dif.ALUOp, dif.Illegal}, e.ctrl);
         end
      end else if (rst && !dif.out_valid)
         chk("bubble_gate", {dif.RegWrite, dif.MemWrite, dif.Branch, dif.Jump, dif.Illegal}, 0);
   end
   task automatic cyc(input logic v, input logic [31:0] ins, input logic rdy, input logic fl,
                      output logic acc);
      exp_t e;
      @(posedge clk);
      #1;
      dif.in_valid  = v;
      dif.in_instr  = ins;
      dif.in_pc     = $urandom;
      dif.out_ready = rdy;
      dif.flush     = fl;
      @(negedge clk);
      acc = v && dif.in_ready && !fl;
      if (acc) begin
         e.instr = ins;
         e.pc    = dif.in_pc;
         e.ctrl  = ref_ctrl(ins);
         sb.push_back(e);
      end
      if (fl) sb.delete();
   endtask
   task automatic idle(input logic rdy, input int n);
      logic acc;
      for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, rdy, 1'b0, acc);
   endtask
   task automatic rand_legal(input int k, output logic [31:0] ins);
      logic [31:0] r;
      r = $urandom;
      ins = {r[31:7], OPS[k]};
   endtask
   initial begin
      logic        acc;
      logic [31:0] ins, prev, a, b, c;
      int          tries;
      dif.flush = 0; dif.in_valid = 0; dif.in_instr = 0; dif.in_pc = 0; dif.out_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", dif.out_valid, 0);
      chk("rst_in_ready", dif.in_ready, 1);
      chk("rst_regwrite", dif.RegWrite, 0);
      chk("rst_out_instr", dif.out_instr, 0);
      chk("rst_out_pc", dif.out_pc, 0);
      rst = 1;
      prev = 0;
      for (int i = 0; i < 8; i++) begin
         rand_legal(i, ins);
         cyc(1'b1, ins, 1'b1, 1'b0, acc);
         chk("stream_accept", acc, 1);
         if (i > 0) begin
            chk("stream_lat_valid", dif.out_valid, 1);
            chk("stream_lat_instr", dif.out_instr, prev);
         end
         prev = ins;
      end
      idle(1'b1, 1);
      chk("stream_last_instr", dif.out_instr, prev);
      idle(1'b1, 2);
      rand_legal(0, a); rand_legal(3, b); rand_legal(5, c);
      cyc(1'b1, a, 1'b0, 1'b0, acc);
      chk("stall_acc1", acc, 1);
      cyc(1'b1, b, 1'b0, 1'b0, acc);
      chk("stall_acc2", acc, 1);
      cyc(1'b1, c, 1'b0, 1'b0, acc);
      chk("stall_acc3", acc, 0);
      chk("stall_in_ready", dif.in_ready, 0);
      chk("stall_hold_instr", dif.out_instr, a);
      tries = 0;
      acc = 0;
      while (!acc && tries < 8) begin
         cyc(1'b1, c, 1'b1, 1'b0, acc);
         tries++;
      end
      chk("stall_release_tries", tries, 2);
      idle(1'b1, 3);
      chk("stall_drained", sb.size(), 0);
      cyc(1'b1, 32'h0000_0073, 1'b1, 1'b0, acc);
      cyc(1'b1, 32'h0000_0010, 1'b1, 1'b0, acc);
      idle(1'b1, 1);
      chk("illegal_flag", dif.Illegal, 1);
      idle(1'b1, 2);
      rand_legal(1, a); rand_legal(4, b); rand_legal(7, c);
      cyc(1'b1, a, 1'b0, 1'b0, acc);
      cyc(1'b1, b, 1'b0, 1'b0, acc);
      cyc(1'b1, c, 1'b0, 1'b1, acc);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, acc);
      chk("flush_out_valid", dif.out_valid, 0);
      chk("flush_in_ready", dif.in_ready, 1);
      idle(1'b1, 3);
      chk("flush_stays_empty", dif.out_valid, 0);
      cyc(1'b1, a, 1'b0, 1'b0, acc);
      cyc(1'b1, b, 1'b0, 1'b0, acc);
      @(posedge clk);
      #3 rst = 0;
      #1;
      chk("arst_out_valid", dif.out_valid, 0);
      chk("arst_regwrite", dif.RegWrite, 0);
      chk("arst_in_ready", dif.in_ready, 1);
      sb.delete();
      dif.in_valid = 0;
      @(posedge clk);
      #1 rst = 1;
      for (int n = 0; n < 400; n++) begin
         logic v, rdy, fl;
         v   = ($urandom % 4) != 0;
         rdy = ($urandom % 3) != 0;
         fl  = ($urandom % 25) == 0;
         if (fl) rdy = 0;
         if (($urandom % 4) != 0) rand_legal(int'($urandom % 8), ins);
         else ins = $urandom;
         cyc(v, ins, rdy, fl, acc);
      end
      tries = 0;
      while (sb.size() != 0 && tries < 10) begin
         idle(1'b1, 1);
         tries++;
      end
      chk("random_drained", sb.size(), 0);
`ifdef DECODER_PERF_EN
      @(posedge clk);
      #1 rst = 0;
      @(posedge clk);
      #1 rst = 1;
      rand_legal(2, a);
      cyc(1'b1, a, 1'b0, 1'b0, acc);
      idle(1'b0, 5);
      for (int i = 1; i < 20; i++) begin
         if (i == 3 || i == 9 || i == 15) ins = 32'h0000_0073;
         else rand_legal(i % 8, ins);
         cyc(1'b1, ins, 1'b1, 1'b0, acc);
      end
      idle(1'b1, 3);
      chk("perf_issued", cnt_issued, 15);
      chk("perf_illegal", cnt_illegal, 3);
      chk("perf_stall", cnt_stall, 5);
      chk("perf_drained", sb.size(), 0);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
